// File: rtl/complex_div_seq.sv
// complex_div_seq: sequential fixed-point complex divider, q = num / den.
// Operands and result are packed {real, imag}. Each component is a signed
// TOTAL_BITS-wide fixed-point value with FX_BITS fractional bits.
// A single restoring divider computes the real part, then the imaginary part.
// Only one operation is in flight at a time.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operand pair valid
//   in_ready     high only while idle
//   num_in       dividend {a, b} = a + jb
//   den_in       divisor  {c, d} = c + jd
//   out_valid    result valid, held until out_ready
//   out_ready    downstream accepts the result
//   q_out        quotient {re, im}
//   div_by_zero  set together with out_valid when c == d == 0
module complex_div_seq #(
  parameter int unsigned TOTAL_BITS = 8,
  parameter int unsigned FX_BITS    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*TOTAL_BITS-1:0] num_in,
  input  logic [2*TOTAL_BITS-1:0] den_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*TOTAL_BITS-1:0] q_out,
  output logic                    div_by_zero
);

  localparam int unsigned W  = TOTAL_BITS;
  localparam int unsigned PW = 2 * W + 1;          // product / sum width
  localparam int unsigned QW = W - 1;              // quotient magnitude bits
  localparam int unsigned AW = PW + FX_BITS + QW;  // divider accumulator width
  localparam int unsigned CW = $clog2(QW + 1);
  localparam logic [CW-1:0] LastCnt = CW'(QW - 1);

  typedef enum logic [2:0] {
    StIdle,
    StMult,
    StDivRe,
    StDivIm,
    StDone
  } state_e;

  state_e r_state, w_state_nx;

  // Latched operands
  logic signed [W-1:0] r_a, r_b, r_c, r_d;

  // Values registered in the multiply cycle
  logic          r_nr_neg, r_ni_neg;
  logic [PW-1:0] r_ni_mag;
  logic [PW-1:0] r_den;
  logic          r_sat_re, r_sat_im;
  logic          r_dz;

  // Divider state
  logic [AW-1:0] r_rem;
  logic [AW-1:0] r_dsh;
  logic [QW-1:0] r_quo;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_q_re;

  // Result registers
  logic [2*W-1:0] r_q;
  logic           r_dbz;

  // Sign-extended operands and products
  logic signed [PW-1:0] w_ae, w_be, w_ce, w_de;
  logic signed [PW-1:0] w_nr, w_ni, w_dsq;
  logic [PW-1:0]        w_nr_mag, w_ni_mag, w_den;
  logic                 w_sat_re, w_sat_im;

  // Divider step
  logic          w_ge;
  logic [AW-1:0] w_rem_sub;
  logic [QW-1:0] w_quo_nx;
  logic          w_last;

  always_comb begin
    w_ae = {{(PW-W){r_a[W-1]}}, r_a};
    w_be = {{(PW-W){r_b[W-1]}}, r_b};
    w_ce = {{(PW-W){r_c[W-1]}}, r_c};
    w_de = {{(PW-W){r_d[W-1]}}, r_d};

    w_nr  = w_ae * w_ce + w_be * w_de;
    w_ni  = w_be * w_ce - w_ae * w_de;
    w_dsq = w_ce * w_ce + w_de * w_de;

    w_nr_mag = w_nr[PW-1] ? -w_nr : w_nr;
    w_ni_mag = w_ni[PW-1] ? -w_ni : w_ni;
    w_den    = w_dsq;

    // Quotient would need more than QW magnitude bits
    w_sat_re = (AW'(w_nr_mag) << FX_BITS) >= (AW'(w_den) << QW);
    w_sat_im = (AW'(w_ni_mag) << FX_BITS) >= (AW'(w_den) << QW);
  end

  always_comb begin
    w_ge      = r_rem >= r_dsh;
    w_rem_sub = r_rem - r_dsh;
    w_quo_nx  = {r_quo[QW-2:0], w_ge};
    w_last    = (r_cnt == LastCnt);
  end

  // Apply saturation and sign. Negating a zero magnitude yields zero, so a
  // zero result never comes out as the most negative code.
  function automatic logic [W-1:0] fmt_part(input logic [QW-1:0] mag,
                                            input logic          neg,
                                            input logic          sat);
    logic [W-1:0] m;
    m = sat ? {1'b0, {QW{1'b1}}} : {1'b0, mag};
    fmt_part = neg ? -m : m;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      StIdle:  if (in_valid) w_state_nx = StMult;
      StMult:  w_state_nx = StDivRe;
      // Zero divisor is seen on the registered flag, so the result appears
      // one cycle after the multiply.
      StDivRe: begin
        if (r_dz) begin
          w_state_nx = StDone;
        end else if (w_last) begin
          w_state_nx = StDivIm;
        end
      end
      StDivIm: if (w_last) w_state_nx = StDone;
      StDone:  if (out_ready) w_state_nx = StIdle;
      default: w_state_nx = StIdle;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_nr_neg <= 1'b0;
      r_ni_neg <= 1'b0;
      r_ni_mag <= '0;
      r_den    <= '0;
      r_sat_re <= 1'b0;
      r_sat_im <= 1'b0;
      r_dz     <= 1'b0;
      r_rem    <= '0;
      r_dsh    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_q_re   <= '0;
      r_q      <= '0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a   <= num_in[2*W-1:W];
            r_b   <= num_in[W-1:0];
            r_c   <= den_in[2*W-1:W];
            r_d   <= den_in[W-1:0];
            r_dbz <= 1'b0;
          end
        end
        StMult: begin
          r_nr_neg <= w_nr[PW-1];
          r_ni_neg <= w_ni[PW-1];
          r_ni_mag <= w_ni_mag;
          r_den    <= w_den;
          r_sat_re <= w_sat_re;
          r_sat_im <= w_sat_im;
          r_dz     <= (w_den == '0);
          // Divisor pre-shifted to align with the first (MSB) quotient bit
          r_rem    <= AW'(w_nr_mag) << FX_BITS;
          r_dsh    <= AW'(w_den) << (QW - 1);
          r_quo    <= '0;
          r_cnt    <= '0;
        end
        StDivRe: begin
          if (r_dz) begin
            r_q   <= '0;
            r_dbz <= 1'b1;
          end else begin
            r_rem <= w_ge ? w_rem_sub : r_rem;
            r_dsh <= r_dsh >> 1;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_q_re <= fmt_part(w_quo_nx, r_nr_neg, r_sat_re);
              r_rem  <= AW'(r_ni_mag) << FX_BITS;
              r_dsh  <= AW'(r_den) << (QW - 1);
              r_cnt  <= '0;
            end
          end
        end
        StDivIm: begin
          r_rem <= w_ge ? w_rem_sub : r_rem;
          r_dsh <= r_dsh >> 1;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_q   <= {r_q_re, fmt_part(w_quo_nx, r_ni_neg, r_sat_im)};
            r_dbz <= 1'b0;
            r_cnt <= '0;
          end
        end
        StDone: begin
          // Hold result until handshake
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready    = (r_state == StIdle);
  assign out_valid   = (r_state == StDone);
  assign q_out       = r_q;
  assign div_by_zero = r_dbz;

endmodule
